// File: rtl/i2s_tx.sv
// i2s_tx: one-deep sample buffer plus I2S serialiser (BCLK/LRCLK/SDATA) driven from the system clock.
// Rev 1.0 - initial release.
`default_nettype none

module i2s_tx #(
  parameter int BCLK_DIV  = 8,
  parameter int SLOT_BITS = 32
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [23:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        frame_start,
  output logic        underrun
);

  localparam int              FRAME_BITS = 2 * SLOT_BITS;
  localparam int              CW         = $clog2(FRAME_BITS);
  localparam logic [7:0]      DIV_LAST   = 8'(BCLK_DIV - 1);
  localparam logic [CW-1:0]   BIT_LAST   = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0]   SLOT       = CW'(SLOT_BITS);

  logic [7:0]    div_cnt;
  logic [CW-1:0] bit_cnt;
  logic          hold_full;
  logic [23:0]   hold_reg;
  logic [23:0]   frame_reg;

  logic          tc;
  logic          fall;
  logic [CW-1:0] next_bit;
  logic [CW-1:0] slot_pos;
  logic          frame_load;
  logic          accept;
  logic          sdata_next;
  logic [4:0]    msb_idx;

  assign tc           = (div_cnt == DIV_LAST);
  assign fall         = tc && i2s_bclk;
  assign next_bit     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  assign slot_pos     = (next_bit >= SLOT) ? next_bit - SLOT : next_bit;
  assign frame_load   = fall && (next_bit == '0);
  assign accept       = sample_valid && !hold_full;
  assign sample_ready = !hold_full;

  // Slot position 0 is the I2S one-bit delay; positions 1..24 carry MSB..LSB.
  always_comb begin
    sdata_next = 1'b0;
    msb_idx    = 5'd0;
    if (slot_pos >= CW'(1) && slot_pos <= CW'(24)) begin
      msb_idx    = 5'(CW'(24) - slot_pos);
      sdata_next = frame_reg[msb_idx];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt     <= '0;
      bit_cnt     <= BIT_LAST;
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_sdata   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      hold_full   <= 1'b0;
      hold_reg    <= '0;
      frame_reg   <= '0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      if (tc) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt  <= div_cnt + 8'd1;
      end

      if (fall) begin
        bit_cnt   <= next_bit;
        i2s_lrclk <= (next_bit >= SLOT);
        i2s_sdata <= sdata_next;
      end

      // On an empty buffer the previous sample repeats and the gap is flagged.
      if (frame_load) begin
        frame_start <= 1'b1;
        if (hold_full) begin
          frame_reg <= hold_reg;
        end else begin
          underrun  <= 1'b1;
        end
      end

      if (accept) begin
        hold_reg  <= sample_in;
        hold_full <= 1'b1;
      end else if (frame_load) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Output stage directly downstream of the pedal router. Consumes the routed 24-bit mono audio sample and serialises it onto an I2S link (BCLK/LRCLK/SDATA) to the output DAC.
- Includes a one-deep holding buffer with a valid/ready handshake.
- Generates all serial clocks from the system clock.
- Emits a frame-start strobe that upstream logic uses as its sample-rate tick.

Parameters:
- BCLK_DIV, 8, Clk cycles per BCLK half-period. Legal range 1..255. BCLK period = 2*BCLK_DIV Clk cycles.
- SLOT_BITS, 32, BCLKs per channel slot (frame = 2*SLOT_BITS). Legal range 25..64.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- sample_in  in  24  two's-complement audio sample (router audio_out).
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  holding buffer can accept a sample this cycle.
- i2s_bclk  out  1  serial bit clock.
- i2s_lrclk  out  1  word select: 0 = left, 1 = right.
- i2s_sdata  out  1  serial data, MSB first.
- frame_start  out  1  one-Clk pulse when a new frame begins.
- underrun  out  1  one-Clk pulse when a frame starts with the holding buffer empty.

Behaviour:
- Reset (async assert, sync-free release): all of the following clear immediately, including mid-frame; no partial frame resumes.
  - i2s_bclk = 0, i2s_lrclk = 0, i2s_sdata = 0.
  - frame_start = 0, underrun = 0.
  - sample_ready = 1.
  - div_cnt = 0, bit_cnt = 2*SLOT_BITS-1.
  - hold_full = 0, hold_reg = 0, frame_reg = 0.
- Clock divider:
  - div_cnt counts 0..BCLK_DIV-1. On the terminal count it wraps to 0 and i2s_bclk toggles.
  - Terminal count with bclk = 1 is a "fall event"; with bclk = 0 it is a "rise event".
  - The first fall event occurs 2*BCLK_DIV Clk cycles after reset release.
- Bit counter (fall events only):
  - bit_cnt increments modulo 2*SLOT_BITS.
  - i2s_lrclk <= (new bit_cnt >= SLOT_BITS).
  - i2s_sdata <= bit for new slot position p = new bit_cnt mod SLOT_BITS:
    - p = 0 → 0 (standard I2S one-BCLK delay after the LRCLK edge);
    - p = 1..24 → frame_reg[24-p];
    - p = 25..SLOT_BITS-1 → 0.
  - Both channels carry the same frame_reg (mono duplicate).
  - All outputs are registered and change only on fall events, so the DAC samples on BCLK rising edges.
- Frame load (fall event where bit_cnt wraps to 0):
  - If hold_full: frame_reg <= hold_reg, hold_full <= 0.
  - Else: frame_reg is unchanged (last sample repeats) and underrun pulses for 1 Clk.
  - frame_start pulses for 1 Clk in the same cycle that lrclk goes low.
  - The slot-1 MSB for the new frame is taken from the newly loaded value.
- Handshake:
  - sample_ready = !hold_full (combinational from the register).
  - Transfer occurs when sample_valid && sample_ready: hold_reg <= sample_in, hold_full <= 1.
  - sample_in is ignored when not ready; nothing is overwritten.
  - If a transfer and a frame load occur in the same cycle: the frame loads the old hold_reg only if hold_full was already 1 (ready = 0, so no transfer). If hold was empty, underrun fires, the transfer is captured into hold, and hold_full = 1 afterwards.
- Latency:
  - A sample accepted at cycle N is emitted starting at the next frame load after N.
  - Its MSB appears on sdata at the second fall event of that frame.
- Throughput: one sample per frame (2*SLOT_BITS*2*BCLK_DIV Clk cycles). Upstream must pace on frame_start.

Test Plan:
- Reset then idle, BCLK_DIV=2, SLOT_BITS=32 → bclk period 4 Clk; lrclk period 256 Clk, low for 128; frame_start every 256 Clk; underrun every frame; sdata stays 0.
- Push 24'h800001 before the first frame → left and right slots each show sdata = 1, 22×0, 1 on p = 1..24; p = 0 and p = 25..31 read 0; no underrun that frame.
- Push 24'hA5A5A5, then offer 24'h123456 immediately → sample_ready = 0 until the next frame load; second value accepted the cycle after that load and serialised in the following frame.
- No push after 24'h7FFFFF is sent → next frame repeats 7FFFFF with one underrun pulse, coincident with frame_start.
- sample_valid asserted in the exact frame-load cycle with hold empty → underrun = 1, hold_full = 1 next cycle, value transmitted in the following frame.
- Assert Reset_n = 0 mid-right-slot (bit_cnt = 40) → all outputs 0 within the same cycle; after release, first frame_start occurs exactly 2*BCLK_DIV Clk later.
